// File: rtl/pattern_seq_ctrl_if.sv
// Pattern RAM port and output word stream bundle for pattern_seq_ctrl.
// The master side is the sequencer. The slave side is the RAM plus the stream consumer.
interface pattern_seq_ctrl_if #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 7
) ();
    logic              ram_wren;
    logic [AWIDTH-1:0] ram_wraddr;
    logic [DWIDTH-1:0] ram_di;
    logic              ram_rden;
    logic [AWIDTH-1:0] ram_rdaddr;
    logic [DWIDTH-1:0] ram_dout;
    logic [DWIDTH-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output ram_wren, ram_wraddr, ram_di, ram_rden, ram_rdaddr, out_data, out_valid,
        input  ram_dout, out_ready
    );

    modport slave (
        input  ram_wren, ram_wraddr, ram_di, ram_rden, ram_rdaddr, out_data, out_valid,
        output ram_dout, out_ready
    );
endinterface

// File: rtl/pattern_seq_ctrl.sv
// Read sequencer and host write gate for the output-function pattern RAM.
// The RAM has a 1-cycle registered read. A 2-entry buffer plus a credit check keeps
// the stream at 1 word/cycle and ensures the buffer never overflows.
//
// state | meaning
// IDLE  | waiting for start; host writes allowed
// RUN   | issuing reads over the latched address range
// DRAIN | no new reads; delivering in-flight and buffered words
module pattern_seq_ctrl #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AWIDTH-1:0] cfg_start_addr,
    input  logic [AWIDTH-1:0] cfg_end_addr,
    input  logic              cfg_loop,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    output logic              done,
    input  logic              wr_req,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    output logic              wr_err,
    pattern_seq_ctrl_if.master bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    state_t            state, state_nxt;
    logic [AWIDTH-1:0] start_q, end_q, rd_ptr;
    logic              loop_q;
    logic              rd_inflight;
    logic              rden;
    logic [DWIDTH-1:0] fifo_mem [2];
    logic              wr_sel, rd_sel;
    logic [1:0]        fifo_cnt;
    logic              push, pop, credit_ok, last_issue, drained;

    // The word read last cycle is on ram_dout now, so it is pushed this cycle.
    assign push       = rd_inflight;
    assign pop        = bus.out_valid & bus.out_ready;
    assign credit_ok  = ({1'b0, fifo_cnt} + {2'b00, rd_inflight}) < (3'd2 + {2'b00, pop});
    assign last_issue = rden & (rd_ptr == end_q);
    assign drained    = ~rd_inflight & (fifo_cnt == {1'b0, pop});

    assign bus.out_valid  = (fifo_cnt != 2'd0);
    assign bus.out_data   = fifo_mem[rd_sel];
    assign bus.ram_rden   = rden;
    assign bus.ram_rdaddr = rd_ptr;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state, read issue and busy decode
    always_comb begin
        state_nxt = state;
        rden      = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // Gated by reset_n so no read escapes during a synchronous reset cycle.
                rden = credit_ok & reset_n;
                if (stop || (last_issue && !loop_q)) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drained) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Range latch and read pointer; the pointer wraps naturally modulo 2^AWIDTH
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            start_q     <= '0;
            end_q       <= '0;
            loop_q      <= 1'b0;
            rd_ptr      <= '0;
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= rden;
            if (state == ST_IDLE && start) begin
                start_q <= cfg_start_addr;
                end_q   <= cfg_end_addr;
                loop_q  <= cfg_loop;
                rd_ptr  <= cfg_start_addr;
            end else if (rden) begin
                rd_ptr <= (last_issue && loop_q) ? start_q : rd_ptr + 1'b1;
            end
        end
    end

    // Two-entry output buffer
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_sel] <= bus.ram_dout;
                wr_sel           <= ~wr_sel;
            end
            if (pop) rd_sel <= ~rd_sel;
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // Host write gate, write-reject pulse and completion pulse
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.ram_wren   <= 1'b0;
            bus.ram_wraddr <= '0;
            bus.ram_di     <= '0;
            wr_err         <= 1'b0;
            done           <= 1'b0;
        end else begin
            bus.ram_wren <= wr_req & (state == ST_IDLE);
            if (wr_req && state == ST_IDLE) begin
                bus.ram_wraddr <= wr_addr;
                bus.ram_di     <= wr_data;
            end
            wr_err <= wr_req & (state != ST_IDLE);
            done   <= (state == ST_DRAIN) & drained;
        end
    end

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Directed bench for pattern_seq_ctrl with a behavioural 1-cycle-read pattern RAM.
module tb_pattern_seq_ctrl;
    localparam int DW = 16;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] cfg_start_addr, cfg_end_addr;
    logic          cfg_loop, start, stop, wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy, done, wr_err;

    int n_total = 0;
    int n_bad   = 0;

    logic [15:0] exp_init [10] = '{16'h0001, 16'hAAAA, 16'h5555, 16'hFFFF, 16'hF0F0,
                                   16'h0F0F, 16'hCCCC, 16'h3333, 16'h0002, 16'h0004};

    always #5 clk = ~clk;

    pattern_seq_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    pattern_seq_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_start_addr (cfg_start_addr),
        .cfg_end_addr   (cfg_end_addr),
        .cfg_loop       (cfg_loop),
        .start          (start),
        .stop           (stop),
        .busy           (busy),
        .done           (done),
        .wr_req         (wr_req),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_err         (wr_err),
        .bus            (bus)
    );

    // Pattern RAM: loads its init table on the first edge, read-first on collisions.
    logic [DW-1:0] mem [0:127];
    logic          mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int a = 0; a < 128; a++) mem[a] <= (a < 10) ? exp_init[a] : 16'h0000;
            mem_ready <= 1'b1;
        end else begin
            if (bus.ram_rden) bus.ram_dout <= mem[bus.ram_rdaddr];
            if (bus.ram_wren) mem[bus.ram_wraddr] <= bus.ram_di;
        end
    end

    // Stream monitor with an independent occupancy model of buffer plus in-flight reads.
    logic [15:0] rx_q [$];
    int          occ_m = 0, infl_m = 0;
    int          credit_viol = 0, valid_viol = 0, hold_viol = 0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data;
    always @(negedge clk) begin
        int pop_m;
        if (!reset_n) begin
            occ_m      = 0;
            infl_m     = 0;
            prev_stall = 1'b0;
        end else begin
            pop_m = (bus.out_valid && bus.out_ready) ? 1 : 0;
            if (bus.out_valid !== (occ_m != 0)) valid_viol++;
            if (bus.ram_rden && (occ_m + infl_m - pop_m >= 2)) credit_viol++;
            if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data)) hold_viol++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            if (pop_m == 1) rx_q.push_back(bus.out_data);
            occ_m  = occ_m + infl_m - pop_m;
            infl_m = bus.ram_rden ? 1 : 0;
            if (occ_m > 2) credit_viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic launch(input logic [AW-1:0] sa, input logic [AW-1:0] ea, input logic lp);
        cfg_start_addr = sa;
        cfg_end_addr   = ea;
        cfg_loop       = lp;
        start          = 1'b1;
        cyc();
        start          = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            mid();
            if (done) begin
                seen = 1'b1;
                break;
            end
            cyc();
        end
        check({tag, "_done"}, seen, 1);
        if (seen) check({tag, "_busy"}, busy, 0);
        cyc();
    endtask

    initial begin
        int base, n_at, errs;
        reset_n = 1'b0;
        start = 0; stop = 0; wr_req = 0; cfg_loop = 0;
        cfg_start_addr = '0; cfg_end_addr = '0; wr_addr = '0; wr_data = '0;
        bus.out_ready = 1'b0;

        // reset with random inputs
        for (int i = 0; i < 3; i++) begin
            cfg_start_addr = AW'($urandom); cfg_end_addr = AW'($urandom);
            cfg_loop = 1'($urandom); start = 1'($urandom); stop = 1'($urandom);
            wr_req = 1'($urandom); wr_addr = AW'($urandom); wr_data = DW'($urandom);
            bus.out_ready = 1'($urandom);
            cyc();
            mid();
            check("rst_rden", bus.ram_rden, 0);
            check("rst_wren", bus.ram_wren, 0);
        end
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_err", wr_err, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_wraddr", bus.ram_wraddr, 0);
        check("rst_rdaddr", bus.ram_rdaddr, 0);
        check("rst_di", bus.ram_di, 0);
        check("rst_data", bus.out_data, 0);
        cyc();
        reset_n = 1'b1;
        start = 0; stop = 0; wr_req = 0;
        bus.out_ready = 1'b1;
        cyc();
        cyc();
        mid();
        check("post_rst_rden", bus.ram_rden, 0);
        check("post_rst_wren", bus.ram_wren, 0);
        cyc();

        // one-shot 0..9 with cycle-exact timing
        launch(0, 9, 0);
        mid();
        check("os_c1_busy", busy, 1);
        check("os_c1_rden", bus.ram_rden, 1);
        check("os_c1_rdaddr", bus.ram_rdaddr, 0);
        cyc(); mid();
        check("os_c2_valid", bus.out_valid, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(); mid();
            check($sformatf("os_w%0d_valid", i), bus.out_valid, 1);
            check($sformatf("os_w%0d_data", i), bus.out_data, exp_init[i]);
        end
        cyc(); mid();
        check("os_c13_done", done, 1);
        check("os_c13_busy", busy, 0);
        cyc(); mid();
        check("os_c14_done", done, 0);
        cyc();

        // backpressure
        base = rx_q.size();
        launch(0, 9, 0);
        for (int c = 0; c < 16; c++) begin
            bus.out_ready = (c % 2 == 0);
            cyc();
        end
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) cyc();
        mid();
        check("bp_stall_valid", bus.out_valid, 1);
        cyc();
        bus.out_ready = 1'b1;
        wait_done("bp");
        check("bp_count", rx_q.size() - base, 10);
        for (int i = 0; i < 10; i++)
            if (base + i < rx_q.size()) check($sformatf("bp_w%0d", i), rx_q[base + i], exp_init[i]);

        // loop 8..9 then stop
        base = rx_q.size();
        launch(8, 9, 1);
        for (int i = 0; i < 50; i++) begin
            mid();
            if (rx_q.size() - base >= 5) break;
            cyc();
        end
        cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        n_at = rx_q.size() - base;
        check("loop_min5", (n_at >= 5), 1);
        wait_done("loop");
        check("loop_extra", ((rx_q.size() - base - n_at) <= 2), 1);
        errs = 0;
        for (int i = base; i < rx_q.size(); i++)
            if (rx_q[i] !== (((i - base) % 2 == 0) ? 16'h0002 : 16'h0004)) errs++;
        check("loop_pattern", errs, 0);

        // host writes then wrap-around range 127..0
        wr_req = 1'b1; wr_addr = 7'd127; wr_data = 16'h1234;
        cyc();
        wr_addr = 7'd0; wr_data = 16'h5678;
        mid();
        check("wr1_wren", bus.ram_wren, 1);
        check("wr1_addr", bus.ram_wraddr, 127);
        check("wr1_di", bus.ram_di, 16'h1234);
        cyc();
        wr_req = 1'b0;
        mid();
        check("wr2_addr", bus.ram_wraddr, 0);
        check("wr2_di", bus.ram_di, 16'h5678);
        cyc();
        base = rx_q.size();
        launch(127, 0, 0);
        wait_done("wrap");
        check("wrap_count", rx_q.size() - base, 2);
        if (rx_q.size() - base >= 2) begin
            check("wrap_w0", rx_q[base], 16'h1234);
            check("wrap_w1", rx_q[base + 1], 16'h5678);
        end

        // write while busy is rejected
        launch(0, 9, 0);
        wr_req = 1'b1; wr_addr = 7'd3; wr_data = 16'hDEAD;
        cyc();
        wr_req = 1'b0;
        mid();
        check("gate_wr_err", wr_err, 1);
        check("gate_wren", bus.ram_wren, 0);
        cyc(); mid();
        check("gate_wr_err_width", wr_err, 0);
        cyc();
        wait_done("gate");

        // reset mid-stream
        launch(0, 9, 0);
        for (int c = 0; c < 3; c++) cyc();
        mid();
        check("mrst_pre_valid", bus.out_valid, 1);
        cyc();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        mid();
        check("mrst_valid", bus.out_valid, 0);
        check("mrst_busy", busy, 0);
        cyc();

        // readback of the gated address, then a normal run after reset
        base = rx_q.size();
        launch(3, 3, 0);
        wait_done("rb");
        check("rb_count", rx_q.size() - base, 1);
        if (rx_q.size() > base) check("rb_data", rx_q[base], 16'hFFFF);
        base = rx_q.size();
        launch(8, 9, 0);
        wait_done("rerun");
        check("rerun_count", rx_q.size() - base, 2);
        if (rx_q.size() - base >= 2) begin
            check("rerun_w0", rx_q[base], 16'h0002);
            check("rerun_w1", rx_q[base + 1], 16'h0004);
        end

        check("credit_rule", credit_viol, 0);
        check("valid_model", valid_viol, 0);
        check("stall_hold", hold_viol, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
